ram8221_ctl: RTL and testbench

- Synchronous initiator/controller for one 82S21-style 32x2 write-while-read bipolar RAM.
- Converts a valid/ready request stream (read or write, 5-bit address, 2-bit data) into the RAM's CE/STROBE/WE0_N/WE1_N/WCLK_N pulse sequence.
- Returns read data, or write readback data, on a response handshake.
- After reset, sweeps all 32 locations to 0 before accepting requests. Sits between CADR microcode-side logic and the RAM model/part.

---
 rtl/ram8221_pkg.sv | 58 +++++
 rtl/ram8221_phase_timer.sv | 26 ++
 rtl/ram8221_ctl.sv | 136 +++++++++++++
 tb/tb_ram8221_ctl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram8221_pkg.sv
// Shared types and constants for the 82S21 32x2 write-while-read RAM controller.
package ram8221_pkg;

  localparam int unsigned RAM_DEPTH = 32;
  localparam int unsigned RAM_AW    = 5;
  localparam int unsigned RAM_DW    = 2;

  typedef enum logic [3:0] {
    CLR_SETUP,
    CLR_PULSE,
    CLR_HOLD,
    IDLE,
    RD_ACCESS,
    RD_LATCH,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RESP
  } state_e;

  typedef struct packed {
    logic       ce;
    logic       strobe;
    logic [1:0] we_n;    // {we1_n, we0_n}
    logic       wclk_n;
  } ram_ctl_t;

  localparam ram_ctl_t CTL_IDLE = '{ce: 1'b0, strobe: 1'b0, we_n: 2'b11, wclk_n: 1'b1};

  // RAM control levels that must be present while the FSM sits in state s.
  function automatic ram_ctl_t ctl_for(state_e s);
    ram_ctl_t c;
    c = CTL_IDLE;
    unique case (s)
      CLR_SETUP, CLR_HOLD, WR_SETUP, WR_HOLD: begin
        c.ce     = 1'b1;
        c.strobe = 1'b1;
        c.we_n   = 2'b00;
      end
      CLR_PULSE, WR_PULSE: begin
        c.ce     = 1'b1;
        c.strobe = 1'b1;
        c.we_n   = 2'b00;
        c.wclk_n = 1'b0;
      end
      RD_ACCESS: begin
        c.ce     = 1'b1;
        c.strobe = 1'b1;
      end
      RD_LATCH: begin
        c.ce     = 1'b1;
      end
      default: c = CTL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ram8221_phase_timer.sv
// 4-bit phase down counter: loaded on phase entry, done when it reaches zero.
module ram8221_phase_timer #(
  parameter logic [3:0] RST_VAL = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/ram8221_ctl.sv
// Request/response controller for one 82S21 32x2 RAM, with zero-fill sweep after reset.
module ram8221_ctl
  import ram8221_pkg::*;
#(
  parameter int unsigned T_SETUP        = 1,
  parameter int unsigned T_PULSE        = 2,
  parameter int unsigned T_HOLD         = 1,
  parameter int unsigned T_ACCESS       = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [RAM_AW-1:0] req_addr,
  input  logic [RAM_DW-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RAM_DW-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done,
  output logic [RAM_AW-1:0] ram_a,
  output logic [RAM_DW-1:0] ram_i,
  output logic              ram_ce,
  output logic              ram_strobe,
  output logic              ram_we0_n,
  output logic              ram_we1_n,
  output logic              ram_wclk_n,
  input  logic [RAM_DW-1:0] ram_d
);

  localparam state_e RST_STATE = CLEAR_ON_RESET ? CLR_SETUP : IDLE;

  state_e     state, next;
  ram_ctl_t   ctl;
  logic       accept;
  logic       clr_last;
  logic       tmr_load;
  logic       tmr_done;
  logic [3:0] tmr_val;

  assign accept   = req_valid && req_ready;
  assign clr_last = (ram_a == RAM_AW'(RAM_DEPTH - 1));

  // Reset preloads T_SETUP (not T_SETUP-1): the first cycle after release
  // lets the registered controls catch up with the CLR_SETUP state.
  ram8221_phase_timer #(
    .RST_VAL(4'(T_SETUP))
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RST_STATE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      CLR_SETUP: if (tmr_done) next = CLR_PULSE;
      CLR_PULSE: if (tmr_done) next = CLR_HOLD;
      CLR_HOLD:  if (tmr_done) next = clr_last ? IDLE : CLR_SETUP;
      IDLE:      if (accept)   next = req_write ? WR_SETUP : RD_ACCESS;
      RD_ACCESS: if (tmr_done) next = RD_LATCH;
      RD_LATCH:                next = RESP;
      WR_SETUP:  if (tmr_done) next = WR_PULSE;
      WR_PULSE:  if (tmr_done) next = WR_HOLD;
      WR_HOLD:   if (tmr_done) next = RESP;
      RESP:      if (rsp_ready) next = IDLE;
      default:                 next = RST_STATE;
    endcase
  end

  always_comb begin
    tmr_load = (next != state);
    tmr_val  = '0;
    unique case (next)
      CLR_SETUP, WR_SETUP: tmr_val = 4'(T_SETUP - 1);
      CLR_PULSE, WR_PULSE: tmr_val = 4'(T_PULSE - 1);
      CLR_HOLD,  WR_HOLD:  tmr_val = 4'(T_HOLD - 1);
      RD_ACCESS:           tmr_val = 4'(T_ACCESS - 1);
      default:             tmr_val = '0;
    endcase
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl       <= CTL_IDLE;
      ram_a     <= '0;
      ram_i     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      init_done <= !CLEAR_ON_RESET;
    end else begin
      ctl       <= ctl_for(next);
      req_ready <= (next == IDLE);
      rsp_valid <= (next == RESP);

      if (accept) begin
        ram_a <= req_addr;
        if (req_write) ram_i <= req_wdata;
      end else if (state == CLR_HOLD && tmr_done && !clr_last) begin
        ram_a <= ram_a + 1'b1;
      end

      if (state == CLR_HOLD && tmr_done && clr_last) init_done <= 1'b1;

      if (state == RD_LATCH) begin
        rsp_rdata <= ram_d;
        rsp_err   <= 1'b0;
      end else if (state == WR_HOLD && tmr_done) begin
        rsp_rdata <= ram_d;
        rsp_err   <= (ram_d != ram_i);
      end
    end
  end

  assign ram_ce     = ctl.ce;
  assign ram_strobe = ctl.strobe;
  assign ram_we0_n  = ctl.we_n[0];
  assign ram_we1_n  = ctl.we_n[1];
  assign ram_wclk_n = ctl.wclk_n;

endmodule

// File: tb/tb_ram8221_ctl.sv
// Self-checking bench for ram8221_ctl with a behavioural 82S21 model and a response scoreboard.
module tb_ram8221_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_write;
  logic [4:0] req_addr;
  logic [1:0] req_wdata;
  logic       rsp_valid, rsp_ready, rsp_err, init_done;
  logic [1:0] rsp_rdata;
  logic [4:0] ram_a;
  logic [1:0] ram_i, ram_d;
  logic       ram_ce, ram_strobe, ram_we0_n, ram_we1_n, ram_wclk_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram8221_ctl #(
    .T_SETUP       (1),
    .T_PULSE       (2),
    .T_HOLD        (1),
    .T_ACCESS      (2),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done),
    .ram_a     (ram_a),
    .ram_i     (ram_i),
    .ram_ce    (ram_ce),
    .ram_strobe(ram_strobe),
    .ram_we0_n (ram_we0_n),
    .ram_we1_n (ram_we1_n),
    .ram_wclk_n(ram_wclk_n),
    .ram_d     (ram_d)
  );

  // RAM model: writes while ce and wclk_n low, output latch transparent while strobe high.
  logic [1:0] mem [32];
  logic [1:0] lat = 2'b00;
  bit         force_en = 1'b0;
  logic [1:0] force_val = 2'b00;
  assign ram_d = force_en ? force_val : lat;

  always @(negedge clk) begin
    if (ram_ce && !ram_wclk_n) begin
      if (!ram_we0_n) mem[ram_a][0] = ram_i[0];
      if (!ram_we1_n) mem[ram_a][1] = ram_i[1];
    end
    if (ram_ce && ram_strobe) lat = mem[ram_a];
  end

  // Write-clock ordering monitor, suspended around reset.
  logic       prev_wclk = 1'b1;
  logic [4:0] prev_a = '0;
  bit         was_reset = 1'b1;
  always @(negedge clk) begin
    if (!reset && !was_reset) begin
      if (prev_wclk && !ram_wclk_n) begin
        checks++;
        if (!(ram_ce && !ram_we0_n && !ram_we1_n))
          $display("FAIL wclk_fall_qual: ce=%b we_n=%b%b required ce=1 we_n=00", ram_ce, ram_we1_n, ram_we0_n);
        if (!(ram_ce && !ram_we0_n && !ram_we1_n)) errors++;
      end
      if (ram_a != prev_a) begin
        checks++;
        if (!ram_wclk_n || !prev_wclk) begin
          errors++;
          $display("FAIL addr_vs_wclk: addr %h->%h with wclk_n prev=%b now=%b required both 1", prev_a, ram_a, prev_wclk, ram_wclk_n);
        end
      end
    end
    was_reset = reset;
    prev_wclk = ram_wclk_n;
    prev_a    = ram_a;
  end

  typedef struct packed { logic [1:0] rdata; logic err; } exp_t;
  typedef struct packed { logic ce; logic strobe; logic wclk_n; logic [1:0] we_n; logic [4:0] a; } smp_t;

  exp_t       exp_q[$];
  smp_t       hist[$];
  logic [1:0] shadow [32];

  // Drives one request and waits for its response; edges counted with the accept edge as 1.
  task automatic issue(input bit w, input logic [4:0] a, input logic [1:0] d, output int lat_n, output bit ok);
    int n;
    ok = 1'b1;
    lat_n = 0;
    hist.delete();
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      ok = 1'b0;
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      lat_n = 1;
      @(negedge clk);
      req_valid = 1'b0;
      forever begin
        hist.push_back('{ram_ce, ram_strobe, ram_wclk_n, {ram_we1_n, ram_we0_n}, ram_a});
        if (rsp_valid) break;
        if (lat_n > 60) begin
          ok = 1'b0;
          break;
        end
        @(posedge clk);
        lat_n++;
        @(negedge clk);
      end
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; force_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ram_ce, ram_strobe, ram_we0_n, ram_we1_n, ram_wclk_n, ram_a, ram_i} !== {5'b00111, 5'd0, 2'd0}) begin
      errors++;
      $display("FAIL reset_ram_ctl: ce/str/we0/we1/wclk/a/i=%b%b%b%b%b/%h/%b required 00111/00/00",
               ram_ce, ram_strobe, ram_we0_n, ram_we1_n, ram_wclk_n, ram_a, ram_i);
    end
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, init_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_handshake: ready/valid/rdata/err/done=%b%b%b%b%b required all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err, init_done);
    end
    reset = 1'b0;
    bad = 0;
    for (int k = 1; k <= 128; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (req_ready !== 1'b0 || init_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep_busy: %0d of 128 sweep cycles had req_ready or init_done set, required 0", bad);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL sweep_done_c129: req_ready=%b init_done=%b required 1 1", req_ready, init_done);
    end
    req_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== 2'b00) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep_zero: %0d locations nonzero after sweep, required 0", bad);
    end
    for (int i = 0; i < 32; i++) shadow[i] = 2'b00;
  endtask

  task automatic test_write_basic();
    int lat_n, f, l, lows;
    bit ok;
    exp_t e;
    exp_q.push_back('{2'b10, 1'b0});
    shadow[5'h0A] = 2'b10;
    issue(1'b1, 5'h0A, 2'b10, lat_n, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL write_timeout: no response, required one"); end
    checks++;
    if (lat_n != 5) begin errors++; $display("FAIL write_latency: %0d edges, required 5", lat_n); end
    lows = 0; f = -1; l = -1;
    foreach (hist[i]) if (!hist[i].wclk_n) begin
      lows++;
      if (f < 0) f = i;
      l = i;
    end
    checks++;
    if (lows != 2) begin errors++; $display("FAIL wclk_width: low %0d cycles, required 2", lows); end
    checks++;
    if (f < 1 || l + 1 >= hist.size() ||
        hist[f-1] !== '{1'b1, 1'b1, 1'b1, 2'b00, 5'h0A} || hist[l+1] !== '{1'b1, 1'b1, 1'b1, 2'b00, 5'h0A}) begin
      errors++;
      $display("FAIL write_setup_hold: first_low=%0d last_low=%0d samples=%0d, required setup/hold cycles with ce=1 we_n=00 a=0A", f, l, hist.size());
    end
    e = exp_q.pop_front();
    checks++;
    if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++;
      $display("FAIL write_rsp: rdata=%b err=%b required %b %b", rsp_rdata, rsp_err, e.rdata, e.err);
    end
    take_rsp();
  endtask

  task automatic test_read_basic();
    int lat_n, highs, l;
    bit ok;
    exp_t e;
    exp_q.push_back('{shadow[5'h0A], 1'b0});
    issue(1'b0, 5'h0A, 2'b00, lat_n, ok);
    checks++;
    if (!ok || lat_n != 4) begin errors++; $display("FAIL read_latency: ok=%0d %0d edges, required 4", ok, lat_n); end
    highs = 0; l = -1;
    foreach (hist[i]) if (hist[i].strobe) begin highs++; l = i; end
    checks++;
    if (highs != 2 || l < 0 || l + 1 >= hist.size() || hist[l+1].ce !== 1'b1 || hist[l+1].strobe !== 1'b0) begin
      errors++;
      $display("FAIL read_strobe: high %0d cycles last=%0d, required 2 high then 1 with ce=1 strobe=0", highs, l);
    end
    e = exp_q.pop_front();
    checks++;
    if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++;
      $display("FAIL read_rsp: rdata=%b err=%b required %b %b", rsp_rdata, rsp_err, e.rdata, e.err);
    end
    take_rsp();
  endtask

  task automatic test_readback_err();
    int lat_n;
    bit ok;
    exp_t e;
    force_en = 1'b1; force_val = 2'b01;
    exp_q.push_back('{2'b01, 1'b1});
    shadow[5'h1F] = 2'b11;
    issue(1'b1, 5'h1F, 2'b11, lat_n, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++;
      $display("FAIL readback_err: ok=%0d rdata=%b err=%b required %b %b", ok, rsp_rdata, rsp_err, e.rdata, e.err);
    end
    take_rsp();
    force_en = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat_n, bad, n;
    bit ok;
    exp_t e;
    exp_q.push_back('{shadow[5'h0A], 1'b0});
    issue(1'b0, 5'h0A, 2'b00, lat_n, ok);
    e = exp_q.pop_front();
    bad = ok ? 0 : 1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_rsp: %0d unstable cycles (rdata=%b valid=%b ready=%b), required 0 with rdata %b",
               bad, rsp_rdata, rsp_valid, req_ready, e.rdata);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h1F; req_wdata = '0;
    exp_q.push_back('{shadow[5'h1F], 1'b0});
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_during_take: req_ready=%b required 0", req_ready); end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_take: req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL next_accept: req_ready=%b required 0 after accept", req_ready); end
    n = 0;
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++;
      $display("FAIL follow_read: valid=%b rdata=%b err=%b required 1 %b %b", rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
    end
    take_rsp();
  endtask

  task automatic test_back_to_back();
    int lat_n;
    bit ok, w;
    logic [4:0] a;
    logic [1:0] d;
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      w = ($urandom_range(0, 1) == 1);
      a = 5'($urandom_range(0, 31));
      d = 2'($urandom_range(0, 3));
      if (w) begin
        shadow[a] = d;
        exp_q.push_back('{d, 1'b0});
      end else begin
        exp_q.push_back('{shadow[a], 1'b0});
      end
      issue(w, a, d, lat_n, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || lat_n != (w ? 5 : 4) || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        errors++;
        $display("FAIL b2b_%0d: w=%0d a=%h ok=%0d lat=%0d rdata=%b err=%b required lat=%0d %b %b",
                 k, w, a, ok, lat_n, rsp_rdata, rsp_err, w ? 5 : 4, e.rdata, e.err);
      end
      take_rsp();
    end
  endtask

  task automatic test_reset_mid_write();
    int n, lat_n;
    bit ok;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'h03; req_wdata = 2'b11;
    n = 0;
    while (!req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ram_wclk_n !== 1'b0) begin errors++; $display("FAIL mid_in_pulse: wclk_n=%b required 0", ram_wclk_n); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({ram_ce, ram_wclk_n, ram_we1_n, ram_we0_n, rsp_valid, req_ready} !== 6'b011100) begin
      errors++;
      $display("FAIL mid_reset_ctl: ce=%b wclk_n=%b we_n=%b%b rsp_valid=%b req_ready=%b required 0 1 11 0 0",
               ram_ce, ram_wclk_n, ram_we1_n, ram_we0_n, rsp_valid, req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ram_a !== 5'h00 || ram_ce !== 1'b1 || {ram_we1_n, ram_we0_n} !== 2'b00 || ram_i !== 2'b00) begin
      errors++;
      $display("FAIL sweep_restart: a=%h ce=%b we_n=%b%b i=%b required 00 1 00 00", ram_a, ram_ce, ram_we1_n, ram_we0_n, ram_i);
    end
    n = 0;
    while (!init_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("FAIL resweep_done: init_done=%b required 1", init_done); end
    for (int i = 0; i < 32; i++) shadow[i] = 2'b00;
    exp_q.push_back('{shadow[5'h03], 1'b0});
    issue(1'b0, 5'h03, 2'b00, lat_n, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      errors++;
      $display("FAIL addr3_cleared: ok=%0d rdata=%b err=%b required %b %b", ok, rsp_rdata, rsp_err, e.rdata, e.err);
    end
    take_rsp();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 2'($urandom_range(1, 3));
    test_reset();
    test_write_basic();
    test_read_basic();
    test_readback_err();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
